// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format codes, opcode constants and a sign-extend helper
// shared by imm_decode and imm_gen_stage.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ILL   = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Sign-extend the low w bits of v to 64 bits: park bit w-1 at
    // bit 63, then arithmetic-shift back down.
    function automatic logic [63:0] sext(input logic [31:0] v,
                                         input int unsigned w);
        logic signed [63:0] t;
        t = {v, 32'b0};
        t = t <<< (32 - w);
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational format + immediate decode of one instruction.
// Ports: instr_i (raw word), fmt_o, imm_o (XLEN), tgt_en_o (B/J/AUIPC).
// Macro IMM_GEN_RVC_EN enables decoding of a subset of 16-bit RVC words.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output fmt_e            fmt_o,
    output logic [XLEN-1:0] imm_o,
    output logic            tgt_en_o
);

    logic [6:0] opc;
    logic [2:0] f3;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];

    always_comb begin
        fmt_o    = FMT_ILL;
        imm_o    = '0;
        tgt_en_o = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            unique case (opc)
                OPC_OP: fmt_o = FMT_R;
                OPC_OP_IMM: begin
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        fmt_o = FMT_SHAMT;
                        imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20])
                                             : XLEN'(instr_i[24:20]);
                    end else begin
                        fmt_o = FMT_I;
                        imm_o = XLEN'(sext({20'b0, instr_i[31:20]}, 12));
                    end
                end
                OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'(sext({20'b0, instr_i[31:20]}, 12));
                end
                OPC_STORE: begin
                    fmt_o = FMT_S;
                    imm_o = XLEN'(sext({20'b0, instr_i[31:25],
                                        instr_i[11:7]}, 12));
                end
                OPC_BRANCH: begin
                    fmt_o    = FMT_B;
                    tgt_en_o = 1'b1;
                    imm_o    = XLEN'(sext({19'b0, instr_i[31], instr_i[7],
                                           instr_i[30:25], instr_i[11:8],
                                           1'b0}, 13));
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt_o    = FMT_U;
                    tgt_en_o = (opc == OPC_AUIPC);
                    imm_o    = XLEN'(sext({instr_i[31:12], 12'b0}, 32));
                end
                OPC_JAL: begin
                    fmt_o    = FMT_J;
                    tgt_en_o = 1'b1;
                    imm_o    = XLEN'(sext({11'b0, instr_i[31],
                                           instr_i[19:12], instr_i[20],
                                           instr_i[30:21], 1'b0}, 21));
                end
                default: ;
            endcase
        end else begin
`ifdef IMM_GEN_RVC_EN
            // Quadrant 1 only; C.ADDI16SP (C.LUI encoding, rd=x2) stays ILL.
            unique case ({instr_i[1:0], instr_i[15:13]})
                5'b01_000, 5'b01_010: begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'(sext({26'b0, instr_i[12],
                                        instr_i[6:2]}, 6));
                end
                5'b01_011: begin
                    if (instr_i[11:7] != 5'd2) begin
                        fmt_o = FMT_U;
                        imm_o = XLEN'(sext({14'b0, instr_i[12],
                                            instr_i[6:2], 12'b0}, 18));
                    end
                end
                5'b01_101: begin
                    fmt_o    = FMT_J;
                    tgt_en_o = 1'b1;
                    imm_o    = XLEN'(sext({20'b0, instr_i[12], instr_i[8],
                                           instr_i[10:9], instr_i[6],
                                           instr_i[7], instr_i[2],
                                           instr_i[11], instr_i[5:3],
                                           1'b0}, 12));
                end
                5'b01_110, 5'b01_111: begin
                    fmt_o    = FMT_B;
                    tgt_en_o = 1'b1;
                    imm_o    = XLEN'(sext({23'b0, instr_i[12],
                                           instr_i[6:5], instr_i[2],
                                           instr_i[11:10], instr_i[4:3],
                                           1'b0}, 9));
                end
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: immediate generator with a DEPTH-entry output FIFO.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instr/in_pc
// producer side; out_valid/out_ready/out_imm/out_fmt/out_pc/out_target/
// out_count consumer side. Macro IMM_GEN_RVC_EN enables RVC decode.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_imm,
    output logic [2:0]                 out_fmt,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_target,
    output logic [$clog2(DEPTH+1)-1:0] out_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_tgt_en;
    logic [XLEN-1:0] tgt;

    logic [XLEN-1:0] imm_q [DEPTH];
    logic [2:0]      fmt_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] tgt_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr_i  (in_instr),
        .fmt_o    (dec_fmt),
        .imm_o    (dec_imm),
        .tgt_en_o (dec_tgt_en)
    );

    assign tgt = dec_tgt_en ? in_pc + dec_imm : '0;

    // in_ready depends only on count_q, never on out_ready.
    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign out_count = count_q;

    assign push = in_valid && in_ready && !rst;
    assign pop  = out_valid && out_ready && !rst;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage carries no reset; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_q[wr_ptr_q] <= dec_imm;
            fmt_q[wr_ptr_q] <= dec_fmt;
            pc_q[wr_ptr_q]  <= in_pc;
            tgt_q[wr_ptr_q] <= tgt;
        end
    end

    assign out_imm    = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_fmt    = out_valid ? fmt_q[rd_ptr_q] : '0;
    assign out_pc     = out_valid ? pc_q[rd_ptr_q]  : '0;
    assign out_target = out_valid ? tgt_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed + randomized checks of imm_gen_stage
// against a behavioural scoreboard model.
module tb_imm_gen_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_imm, out_pc, out_target;
    logic [2:0]  out_fmt;
    logic [1:0]  out_count;

    logic        x_in_valid, x_in_ready, x_out_valid;
    logic [31:0] x_in_instr;
    logic [63:0] x_in_pc, x_out_imm, x_out_pc, x_out_target;
    logic [2:0]  x_out_fmt;
    logic [1:0]  x_out_count;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  f;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] tgt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_pc(out_pc),
        .out_target(out_target), .out_count(out_count)
    );

    imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_instr(x_in_instr), .in_pc(x_in_pc),
        .out_valid(x_out_valid), .out_ready(1'b1),
        .out_imm(x_out_imm), .out_fmt(x_out_fmt), .out_pc(x_out_pc),
        .out_target(x_out_target), .out_count(x_out_count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint raw, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (raw >= half) ? raw - (longint'(1) << bits) : raw;
    endfunction

    function automatic longint b(input logic x);
        return longint'(x);
    endfunction

    // Reference decode from the ISA field layout, in plain arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] w,
                                     input logic [63:0] pc, input int xl);
        exp_t   e;
        longint v = 0;
        bit     te = 0;
        e.f = 3'd7;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h33: e.f = 3'd0;
                7'h13, 7'h03, 7'h67, 7'h73: begin
                    if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
                        e.f = 3'd6;
                        v = (xl == 32) ? longint'(w[24:20]) : longint'(w[25:20]);
                    end else begin
                        e.f = 3'd1;
                        v = sx(longint'(w[31:20]), 12);
                    end
                end
                7'h23: begin
                    e.f = 3'd2;
                    v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
                end
                7'h63: begin
                    e.f = 3'd3; te = 1;
                    v = sx(b(w[31]) * 4096 + b(w[7]) * 2048
                         + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
                end
                7'h37, 7'h17: begin
                    e.f = 3'd4; te = (w[6:0] == 7'h17);
                    v = sx(longint'(w[31:12]) * 4096, 32);
                end
                7'h6F: begin
                    e.f = 3'd5; te = 1;
                    v = sx(b(w[31]) * (1 << 20) + longint'(w[19:12]) * 4096
                         + b(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
                end
                default: ;
            endcase
        end else begin
`ifdef IMM_GEN_RVC_EN
            if (w[1:0] == 2'b01) begin
                case (w[15:13])
                    3'd0, 3'd2: begin
                        e.f = 3'd1;
                        v = sx(b(w[12]) * 32 + longint'(w[6:2]), 6);
                    end
                    3'd3: if (w[11:7] != 5'd2) begin
                        e.f = 3'd4;
                        v = sx(b(w[12]) * 32 + longint'(w[6:2]), 6) * 4096;
                    end
                    3'd5: begin
                        e.f = 3'd5; te = 1;
                        v = sx(b(w[12]) * 2048 + b(w[11]) * 16
                             + longint'(w[10:9]) * 256 + b(w[8]) * 1024
                             + b(w[7]) * 64 + b(w[6]) * 128
                             + longint'(w[5:3]) * 2 + b(w[2]) * 32, 12);
                    end
                    3'd6, 3'd7: begin
                        e.f = 3'd3; te = 1;
                        v = sx(b(w[12]) * 256 + longint'(w[11:10]) * 8
                             + longint'(w[6:5]) * 64 + longint'(w[4:3]) * 2
                             + b(w[2]) * 32, 9);
                    end
                    default: ;
                endcase
            end
`endif
        end
        e.imm = 64'(v);
        e.pc  = pc;
        e.tgt = te ? e.imm + pc : 64'd0;
        if (xl == 32) begin
            e.imm[63:32] = '0;
            e.tgt[63:32] = '0;
            e.pc[63:32]  = '0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 11))
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h73;
            5:  w[6:0] = 7'h23;
            6:  w[6:0] = 7'h63;
            7:  w[6:0] = 7'h37;
            8:  w[6:0] = 7'h17;
            9:  w[6:0] = 7'h6F;
            10: w[1:0] = 2'b01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk_head(input string tag, input exp_t e);
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".imm"}, 64'(out_imm), e.imm);
        chk({tag, ".fmt"}, 64'(out_fmt), 64'(e.f));
        chk({tag, ".pc"},  64'(out_pc),  e.pc);
        chk({tag, ".tgt"}, 64'(out_target), e.tgt);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".vld"}, 64'(out_valid), 64'd0);
        chk({tag, ".cnt"}, 64'(out_count), 64'd0);
        chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
        chk({tag, ".imm"}, 64'(out_imm), 64'd0);
        chk({tag, ".tgt"}, 64'(out_target), 64'd0);
    endtask

    // Push one word into an empty buffer, check it next cycle, drain it.
    task automatic one_shot(input string tag, input logic [31:0] w,
                            input logic [31:0] pc, input exp_t e);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = w; in_pc = pc;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk_head(tag, e);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drain"}, 64'(out_count), 64'd0);
    endtask

    initial begin
        exp_t e;
        bit   do_push, do_pop;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        x_in_valid = 1'b0; x_in_instr = '0; x_in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_empty("reset");
        rst = 1'b0;

        e = '{f: 3'd1, imm: 64'hFFFF_FFFC, pc: 64'h100, tgt: 64'd0};
        one_shot("addi", 32'hFFC1_0193, 32'h100, e);
        e = '{f: 3'd3, imm: 64'h0000_000C, pc: 64'h200, tgt: 64'h20C};
        one_shot("bge", 32'h0020_D663, 32'h200, e);
        e = '{f: 3'd4, imm: 64'h0000_2000, pc: 64'h40, tgt: 64'd0};
        one_shot("lui", 32'h0000_2537, 32'h40, e);
`ifdef IMM_GEN_RVC_EN
        e = '{f: 3'd1, imm: 64'd1, pc: 64'h80, tgt: 64'd0};
`else
        e = '{f: 3'd7, imm: 64'd0, pc: 64'h80, tgt: 64'd0};
`endif
        one_shot("cli", 32'h0000_4505, 32'h80, e);

        // Back-to-back pushes into DEPTH=2 with the consumer stalled.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h0010_0093; in_pc = 32'h10;
        @(posedge clk); @(negedge clk);
        chk("b2b.cnt1", 64'(out_count), 64'd1);
        chk("b2b.rdy1", 64'(in_ready), 64'd1);
        in_instr = 32'h0020_0093; in_pc = 32'h14;
        @(posedge clk); @(negedge clk);
        chk("b2b.cnt2", 64'(out_count), 64'd2);
        chk("b2b.rdy2", 64'(in_ready), 64'd0);
        in_instr = 32'h0030_0093; in_pc = 32'h18;
        @(posedge clk); @(negedge clk);
        chk("b2b.held", 64'(out_count), 64'd2);
        chk_head("b2b.h0", '{f: 3'd1, imm: 64'd1, pc: 64'h10, tgt: 64'd0});
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b2b.cnt3", 64'(out_count), 64'd1);
        chk_head("b2b.h1", '{f: 3'd1, imm: 64'd2, pc: 64'h14, tgt: 64'd0});
        @(posedge clk); @(negedge clk);
        chk("b2b.cnt4", 64'(out_count), 64'd0);
        out_ready = 1'b0;

        // Reset while full, with in_valid still asserted.
        in_valid = 1'b1; in_instr = 32'h0050_0093;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("rstfull.cnt", 64'(out_count), 64'd2);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_empty("rstmid");
        rst = 1'b0; in_valid = 1'b0;

        // XLEN=64: AUIPC with imm20=0x80000.
        x_in_valid = 1'b1; x_in_instr = 32'h8000_0097; x_in_pc = 64'h1000;
        @(posedge clk); @(negedge clk);
        x_in_valid = 1'b0;
        chk("x64.vld", 64'(x_out_valid), 64'd1);
        chk("x64.imm", x_out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("x64.fmt", 64'(x_out_fmt), 64'd4);
        chk("x64.tgt", x_out_target, 64'hFFFF_FFFF_8000_1000);

        // Randomized traffic against the scoreboard.
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            do_push = in_valid && (sb.size() < DEPTH);
            do_pop  = out_ready && (sb.size() > 0);
            e = ref_dec(in_instr, 64'(in_pc), 32);
            @(posedge clk);
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(e);
            @(negedge clk);
            chk("rnd.cnt", 64'(out_count), 64'(sb.size()));
            chk("rnd.rdy", 64'(in_ready), 64'(sb.size() < DEPTH));
            if (sb.size() > 0) chk_head("rnd", sb[0]);
            else               chk("rnd.vld", 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
